switch_debouncer: RTL and testbench

//   Filters a bouncing mechanical switch/button into a clean level, db.

---
 rtl/switch_debouncer.sv | 126 ++++++++++++
 tb/tb_switch_debouncer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//
// Purpose:
//   Turns a bouncing mechanical switch into a clean level, db. A change of
//   level is accepted only after the sampled input has held the new value for
//   DB_CYCLES consecutive clocks. Any bounce in that window sends the FSM back
//   to its origin state, and the next stable edge starts a full count again.
//   db feeds a rising-edge detector downstream, so one press gives one tick.
//
// Parameters:
//   DB_CYCLES  stable cycles required before db changes (>= 1)
//   CNT_W      counter width, 2**CNT_W >= DB_CYCLES
//
// Ports:
//   clk    in   1  system clock, all state changes on posedge
//   reset  in   1  asynchronous, active-high reset
//   sw     in   1  raw switch input, may bounce
//   db     out  1  debounced level, driven straight from a flop
//
// Configuration macro:
//   DB_SYNC_EN  when defined, sw passes through a 2-flop synchronizer before
//               the FSM, which adds 2 cycles of latency in each direction.
//               When undefined, sw must already be synchronous to clk.
// ---------------------------------------------------------------------------
module switch_debouncer #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db
);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             db_next;
  logic             sw_i;

`ifdef DB_SYNC_EN
  logic sw_sync_p0;
  logic sw_sync_p1;

  // Input synchronizer stages p0 -> p1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_sync_p0 <= 1'b0;
      sw_sync_p1 <= 1'b0;
    end else begin
      sw_sync_p0 <= sw;
      sw_sync_p1 <= sw_sync_p0;
    end
  end

  assign sw_i = sw_sync_p1;
`else
  assign sw_i = sw;
`endif

  // FSM state, counter and registered output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ZERO;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      db    <= db_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ZERO: begin
        if (sw_i) begin
          state_next = WAIT1;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT1: begin
        // A low sample abandons the pending count; no partial credit.
        if (!sw_i)
          state_next = ZERO;
        else if (cnt == '0)
          state_next = ONE;
        else
          cnt_next = cnt - CNT_DEC;
      end
      ONE: begin
        if (!sw_i) begin
          state_next = WAIT0;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (sw_i)
          state_next = ONE;
        else if (cnt == '0)
          state_next = ZERO;
        else
          cnt_next = cnt - CNT_DEC;
      end
      default: state_next = ZERO;
    endcase
    // db is the decode of the next state, registered alongside it, so it
    // always matches the state flops without any combinational path to db.
    db_next = (state_next == ONE) || (state_next == WAIT0);
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_switch_debouncer
//
// Purpose:
//   Scoreboard bench for switch_debouncer. Two instances share the same sw
//   stimulus: one with DB_CYCLES=4 and one with DB_CYCLES=1. A run-length
//   reference model predicts db for every clock edge and queues the
//   expectations; a separate monitor pops them on the falling edge and
//   compares. Rising edges of db are also counted as ticks and checked
//   against the number of presses the model accepted.
// ---------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int D0 = 4;
  localparam int D1 = 1;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic sw      = 1'b0;
  logic db;
  logic db1;
  logic rst_chk = 1'b0;
  logic done    = 1'b0;

  always #5 clk = ~clk;

  switch_debouncer #(.DB_CYCLES(D0), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .db    (db)
  );

  switch_debouncer #(.DB_CYCLES(D1), .CNT_W(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .db    (db1)
  );

  // Scoreboard queues
  logic exp_q[$];
  logic exp1_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: a level flips once the sampled input has differed from
  // the current level on DB_CYCLES+1 consecutive edges.
  int   run0 = 0;
  int   run1 = 0;
  logic mdb0 = 1'b0;
  logic mdb1 = 1'b0;
  logic sh0  = 1'b0;
  logic sh1  = 1'b0;
  int   model_ticks = 0;

  task automatic model_level(input logic s, input int thr,
                             inout int run, inout logic mdb);
    if (s != mdb) begin
      run = run + 1;
      if (run == thr + 1) begin
        mdb = ~mdb;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic model_reset();
    run0 = 0;
    run1 = 0;
    mdb0 = 1'b0;
    mdb1 = 1'b0;
    sh0  = 1'b0;
    sh1  = 1'b0;
  endtask

  // One clock: drive sw, let the edge happen, predict db, queue it.
  task automatic cycle(input logic s);
    logic si;
    logic prev;
    sw = s;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
`ifdef DB_SYNC_EN
      si  = sh1;
      sh1 = sh0;
      sh0 = sw;
`else
      si  = sw;
`endif
      prev = mdb0;
      model_level(si, D0, run0, mdb0);
      model_level(si, D1, run1, mdb1);
      if (!prev && mdb0) model_ticks++;
    end
    exp_q.push_back(mdb0);
    exp1_q.push_back(mdb1);
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input logic s, input int n);
    for (int i = 0; i < n; i++) cycle(s);
  endtask

  // Assert reset between edges and check that db drops without a clock.
  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(1'b0);
    exp1_q.push_back(1'b0);
    rst_chk = 1'b1;
    #1;
    rst_chk = 1'b0;
  endtask

  // Monitor: compares every queued expectation against the outputs.
  int   dut_ticks = 0;
  logic db_prev   = 1'b0;

  initial begin : monitor
    logic e;
    forever begin
      @(negedge clk or posedge rst_chk or posedge done);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (db !== e) begin
          failures++;
          $display("FAIL db_d4 t=%0t got=%b want=%b", $time, db, e);
        end
      end
      while (exp1_q.size() > 0) begin
        e = exp1_q.pop_front();
        checks++;
        if (db1 !== e) begin
          failures++;
          $display("FAIL db_d1 t=%0t got=%b want=%b", $time, db1, e);
        end
      end
      if (db === 1'b1 && db_prev === 1'b0) dut_ticks++;
      db_prev = db;
      if (done) begin
        checks++;
        if (dut_ticks != model_ticks) begin
          failures++;
          $display("FAIL tick_count got=%0d want=%0d", dut_ticks, model_ticks);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin : driver
    int lvl;
    int len;
    #2;
    // Reset state, held over two edges
    async_reset();
    hold(1'b0, 2);
    reset = 1'b0;

    // Idle, then a clean press
    hold(1'b0, 10);
    hold(1'b1, 8);

    // Release with a bounce: 0 x3, 1 x1, then 0 steady
    hold(1'b0, 3);
    hold(1'b1, 1);
    hold(1'b0, 8);

    // Press with a bounce: 1 x2, 0 x1, then 1 steady
    hold(1'b1, 2);
    hold(1'b0, 1);
    hold(1'b1, 8);
    hold(1'b0, 8);

    // Reset in the middle of WAIT1 after two counted cycles
    hold(1'b1, 3);
    async_reset();
    cycle(1'b1);
    reset = 1'b0;
    hold(1'b1, 8);
    hold(1'b0, 8);

    // Random bouncing and steady runs, with one mid-run reset
    for (int i = 0; i < 60; i++) begin
      lvl = int'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 10))
                                        : int'($urandom_range(1, 5));
      hold(lvl[0], len);
      if (i == 30) begin
        async_reset();
        cycle(lvl[0]);
        reset = 1'b0;
      end
    end

    hold(1'b0, 12);
    done = 1'b1;
    #20;
    $display("FAIL monitor_timeout");
    $fatal(1);
  end

endmodule
